// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_hs start/done sequencer for one non-dataflow HLS top.
// Optional per-transaction watchdog: define SEQ_WDOG_EN.
module ap_ctrl_sequencer #(
  parameter int CNT_W    = 16,
  parameter int WDOG_CYC = 1048575
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] cfg_num_trans,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] last_lat,
  output logic             err
);

`ifdef SEQ_WDOG_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_GAP, S_DONE, S_ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_GAP, S_DONE
  } state_e;
`endif

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  state_e state_q, state_d, nxt_cmpl;

  logic [CNT_W-1:0] num_q, num_d, gap_q, gap_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d, lat_q, lat_d;
  logic [CNT_W-1:0] iss_q, iss_d, dn_q, dn_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             start_q, start_d, busy_q, busy_d;
  logic             fin_q, fin_d;
  logic             accept, fire, cmpl, new_txn;

  assign accept  = (state_q == S_IDLE) && go;
  assign fire    = (state_q == S_START) && ap_ready;
  assign cmpl    = (fire && ap_done) ||
                   ((state_q == S_WAIT) && ap_done);
  // a fresh transaction begins whenever START is entered anew
  assign new_txn = (state_d == S_START) &&
                   !((state_q == S_START) && !ap_ready);

`ifdef SEQ_WDOG_EN
  localparam int WdW = $clog2(WDOG_CYC + 1);
  localparam logic [WdW-1:0] WdLim = WdW'(WDOG_CYC);
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d, wd_hit;
  assign wd_hit = (wd_q >= WdLim);
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    nxt_cmpl = S_GAP;
    if (dn_q + One == num_q)  nxt_cmpl = S_DONE;
    else if (gap_q == '0)     nxt_cmpl = S_START;
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (go) state_d = (cfg_num_trans == '0) ? S_DONE : S_START;
      S_START:
        if (ap_ready) state_d = ap_done ? nxt_cmpl : S_WAIT;
`ifdef SEQ_WDOG_EN
        else if (wd_hit) state_d = S_ERR;
`endif
      S_WAIT:
        if (ap_done) state_d = nxt_cmpl;
`ifdef SEQ_WDOG_EN
        else if (wd_hit) state_d = S_ERR;
`endif
      S_GAP:
        if (gcnt_q <= One) state_d = S_START;
      S_DONE:
        if (!go) state_d = S_IDLE;
`ifdef SEQ_WDOG_EN
      S_ERR:
        state_d = S_ERR;
`endif
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d = (state_d == S_START);
    busy_d  = state_d inside {S_START, S_WAIT, S_GAP};
    fin_d   = accept ? 1'b0 : fin_q;
    if (state_d == S_DONE) fin_d = 1'b1;
`ifdef SEQ_WDOG_EN
    if (state_d == S_ERR) fin_d = 1'b1;
    err_d = err_q | (state_d == S_ERR);
`endif
  end

  always_comb begin
    num_d  = num_q;
    gap_d  = gap_q;
    gcnt_d = gcnt_q;
    iss_d  = iss_q;
    dn_d   = dn_q;
    last_d = last_q;
    lat_d  = lat_q;
    if (accept) begin
      num_d  = cfg_num_trans;
      gap_d  = cfg_gap;
      iss_d  = '0;
      dn_d   = '0;
      last_d = '0;
    end
    if (fire) iss_d = iss_q + One;
    if (cmpl) begin
      dn_d   = dn_q + One;
      last_d = lat_q;
      gcnt_d = gap_q;
    end
    if (state_q == S_GAP) gcnt_d = gcnt_q - One;
    if (new_txn)
      lat_d = One;
    else if (state_q inside {S_START, S_WAIT})
      lat_d = (&lat_q) ? lat_q : lat_q + One;
  end

`ifdef SEQ_WDOG_EN
  always_comb begin
    wd_d = wd_q;
    if (new_txn) wd_d = WdW'(1);
    else if (state_q inside {S_START, S_WAIT}) wd_d = wd_q + WdW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYC == 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      num_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      iss_q   <= '0;
      dn_q    <= '0;
      last_q  <= '0;
      lat_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      num_q   <= num_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      iss_q   <= iss_d;
      dn_q    <= dn_d;
      last_q  <= last_d;
      lat_q   <= lat_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign ap_start    = start_q;
  assign ap_continue = 1'b1;
  assign busy        = busy_q;
  assign finish      = fin_q;
  assign issued_cnt  = iss_q;
  assign done_cnt    = dn_q;
  assign last_lat    = last_q;

endmodule
